// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, reads instruction memory over req/ack
// and hands each word to the controller over valid/ready; halts on an all-zero word.
module instr_fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0,
    parameter int PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instruction,
    output logic [9:0]        opcode,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    output logic [15:0]       instr_count
);

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(PC_STEP);

    typedef enum logic [1:0] {IDLE, REQ, PRESENT, HALT} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic              pend, pend_nx;
    logic [ADDR_W-1:0] pend_pc, pend_pc_nx;
    logic [31:0]       instr_nx;
    logic [9:0]        opcode_nx;
    logic [ADDR_W-1:0] pc_out_nx;
    logic [15:0]       count_nx;
    logic              req_nx, valid_nx, halted_nx;
    logic              handshake;
    logic [15:0]       count_inc;

    assign imem_addr = pc;
    assign handshake = instr_valid & instr_ready;
    assign count_inc = (instr_count == 16'hFFFF) ? instr_count : instr_count + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= PC_RST;
            pend        <= 1'b0;
            pend_pc     <= '0;
            instruction <= '0;
            opcode      <= '0;
            pc_out      <= '0;
            instr_count <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            pend        <= pend_nx;
            pend_pc     <= pend_pc_nx;
            instruction <= instr_nx;
            opcode      <= opcode_nx;
            pc_out      <= pc_out_nx;
            instr_count <= count_nx;
            imem_req    <= req_nx;
            instr_valid <= valid_nx;
            halted      <= halted_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        pend_nx    = pend;
        pend_pc_nx = pend_pc;
        instr_nx   = instruction;
        opcode_nx  = opcode;
        pc_out_nx  = pc_out;
        count_nx   = instr_count;
        req_nx     = imem_req;
        valid_nx   = instr_valid;
        halted_nx  = halted;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_nx  = REQ;
                    pc_nx     = PC_RST;
                    count_nx  = '0;
                    req_nx    = 1'b1;
                    halted_nx = 1'b0;
                end
            end
            REQ: begin
                if (start) count_nx = '0;
                if (imem_ack) begin
                    // A redirect seen now or earlier wins over the returned word; the
                    // request stays up and the new address goes out next cycle.
                    if (start || redirect || pend) begin
                        pc_nx   = start ? PC_RST : (redirect ? redirect_pc : pend_pc);
                        pend_nx = 1'b0;
                    end else if (imem_rdata == '0) begin
                        state_nx  = HALT;
                        halted_nx = 1'b1;
                        req_nx    = 1'b0;
                    end else begin
                        instr_nx  = imem_rdata;
                        opcode_nx = imem_rdata[31:22];
                        pc_out_nx = pc;
                        pc_nx     = pc + PC_INC;
                        state_nx  = PRESENT;
                        req_nx    = 1'b0;
                        valid_nx  = 1'b1;
                    end
                end else if (start || redirect) begin
                    // Address must hold until ack, so the target is parked.
                    pend_nx    = 1'b1;
                    pend_pc_nx = start ? PC_RST : redirect_pc;
                end
            end
            PRESENT: begin
                if (start) begin
                    count_nx = '0;
                    pc_nx    = PC_RST;
                end else begin
                    if (handshake) count_nx = count_inc;
                    if (redirect) pc_nx = redirect_pc;
                end
                if (start || redirect || handshake) begin
                    state_nx = REQ;
                    valid_nx = 1'b0;
                    req_nx   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Front-end sequencer that supplies instruction words to the FSM controller. It holds the PC and issues word reads to instruction memory over a req/ack handshake. Each fetched word is presented to the controller with a valid/ready handshake, along with its opcode field. It also accepts branch redirects and halts when it fetches an all-zero word.

Parameters:
ADDR_W, 8, width of PC and instruction-memory byte address
RESET_PC, 0, PC loaded at reset and on start
PC_STEP, 4, PC increment per fetched instruction (byte addressing)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, active-low, asynchronous
start  in  1  pulse: load RESET_PC, clear instr_count, begin fetching
imem_req  out  1  read request to instruction memory
imem_addr  out  ADDR_W  read address, equals pc while imem_req=1
imem_ack  in  1  read complete; imem_rdata valid this cycle
imem_rdata  in  32  instruction word from memory
instr_valid  out  1  instruction/opcode/pc_out valid toward controller
instr_ready  in  1  controller accepts the presented instruction
instruction  out  32  presented instruction word
opcode  out  10  instruction[31:22]
pc_out  out  ADDR_W  address of the presented instruction
redirect  in  1  branch taken; single-cycle pulse
redirect_pc  in  ADDR_W  branch target, sampled when redirect=1
halted  out  1  high while in HALT
instr_count  out  16  accepted-instruction count, saturating

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, redirect_pending=0.
  - All outputs 0: instruction, opcode, pc_out, instr_count, imem_req, instr_valid, halted.
- All outputs are registered.
- States:
  - IDLE: no requests. start → REQ with pc=RESET_PC and instr_count=0. redirect is ignored.
  - REQ:
    - imem_req=1 and imem_addr=pc, held stable until imem_ack. Never drop req before ack.
    - On imem_ack with redirect_pending=1: discard rdata, pc←pending target, clear pending, stay in REQ. The new request is issued the next cycle.
    - On imem_ack with rdata=0: enter HALT, halted=1, nothing presented, pc unchanged.
    - On imem_ack with rdata≠0: latch instruction and opcode, pc_out←pc, pc←pc+PC_STEP, go to PRESENT.
  - PRESENT:
    - instr_valid=1; instruction, opcode and pc_out held stable.
    - instr_valid&instr_ready → instr_count+1 (saturates at 16'hFFFF), go to REQ.
    - instr_valid never drops without a handshake, except on redirect.
  - HALT:
    - halted=1, no requests, redirect ignored.
    - start → REQ from RESET_PC, clear instr_count, halted=0.
- Latency:
  - start at edge N → imem_req=1 after edge N.
  - ack sampled at edge M → instr_valid=1 after edge M.
  - Handshake at edge P → imem_req=1 after edge P.
  - Zero-wait memory (ack while req=1): 2 cycles per instruction.
- Redirect:
  - In REQ without ack that cycle: record redirect_pending and target. The last redirect before ack wins.
  - In REQ with ack the same cycle: rdata discarded, pc←redirect_pc, stay in REQ.
  - In PRESENT: instr_valid drops next cycle, pc←redirect_pc, go to REQ. If instr_ready is also 1 that cycle, the instruction counts as consumed (instr_count increments).
- PC arithmetic is modulo 2^ADDR_W. The address 2^ADDR_W−PC_STEP is followed by 0.
- start in REQ or PRESENT behaves like a redirect to RESET_PC and also clears instr_count. The outstanding ack is discarded.
- start has priority over redirect in the same cycle.

Test Plan:
- Reset then start; memory with zero-wait ack holds 0x8A000000, 0xCB000000, 0x0 at 0, 4, 8; ready=1 → two handshakes with pc_out 0 then 4 and opcode 0x228 then 0x32C; halted=1 after the third ack; instr_count=2.
- Memory acks after 3 wait cycles, instr_ready held low 5 cycles → imem_addr stable through the wait; instr_valid stays high and instruction stays stable until ready; exactly one count increment.
- Redirect to 0x40 while waiting for ack at addr 4 → ack data at 4 discarded; next imem_addr=0x40; pc_out=0x40 on the next presentation.
- Redirect to 0x20 in PRESENT with instr_ready=1 the same cycle → instr_count increments; instr_valid=0 next cycle; next imem_addr=0x20.
- ADDR_W=8 with pc=0xFC and a nonzero word → pc_out=0xFC, next imem_addr=0x00.
- rst_n driven low mid-REQ (asynchronous, not clock-aligned) → imem_req, instr_valid, halted and instr_count all 0 immediately; IDLE after release; no request until start.
